// File: rtl/aes_128_req_sched_pkg.sv
// Shared types for the aes_128 request scheduler: block width and the per-issue tag
// that travels alongside each block through the core.
package aes_sched_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    // Wide enough for the largest supported requester count (8).
    localparam int unsigned MAX_ID_W    = 3;

    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/aes_128_req_sched_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr, ptr moves past the
// winner whenever a grant is issued (a grant is only ever given to a valid request).
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               gnt_any
);

    logic [ID_W-1:0] ptr_q;
    logic [ID_W-1:0] ptr_d;

    always_comb begin
        logic [ID_W-1:0] idx;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = ID_W'((32'(ptr_q) + k) % NUM_REQ);
            if (en && rst_n && !gnt_any && req[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
                gnt_any  = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_any) begin
            ptr_d = (32'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/aes_128_req_sched.sv
// Shares one non-stalling aes_128 pipeline among NUM_REQ requesters: round-robin issue,
// a tag pipe that tracks each block's owner, and one-hot response routing.
module aes_128_req_sched
    import aes_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned AES_LATENCY = 21,
    parameter int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_state,
    input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key,
    output logic [AES_BLOCK_W-1:0]         core_state,
    output logic [AES_BLOCK_W-1:0]         core_key,
    input  logic [AES_BLOCK_W-1:0]         core_out,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [AES_BLOCK_W-1:0]         resp_data,
    output logic                           busy
);

    logic [NUM_REQ-1:0]     gnt;
    logic [ID_W-1:0]        gnt_idx;
    logic                   gnt_any;
    logic [AES_BLOCK_W-1:0] core_state_q, core_state_d;
    logic [AES_BLOCK_W-1:0] core_key_q, core_key_d;
    // Stage 0 sits beside the operand register; the following AES_LATENCY stages track
    // the core, so the last stage lines up with core_out.
    tag_t                   tag_q [AES_LATENCY+1];
    tag_t                   tag_d [AES_LATENCY+1];
    tag_t                   tag_last;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .req     (req_valid),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_comb begin
        core_state_d = core_state_q;
        core_key_d   = core_key_q;
        if (gnt_any) begin
            core_state_d = req_state[32'(gnt_idx)*AES_BLOCK_W +: AES_BLOCK_W];
            core_key_d   = req_key[32'(gnt_idx)*AES_BLOCK_W +: AES_BLOCK_W];
        end
    end

    always_comb begin
        tag_d[0] = '{valid: gnt_any, id: MAX_ID_W'(gnt_idx)};
        for (int unsigned i = 1; i <= AES_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            core_state_q <= '0;
            core_key_q   <= '0;
            for (int unsigned i = 0; i <= AES_LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            core_state_q <= core_state_d;
            core_key_q   <= core_key_d;
            tag_q        <= tag_d;
        end
    end

    always_comb begin
        tag_last   = tag_q[AES_LATENCY];
        resp_valid = '0;
        busy       = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            resp_valid[i] = tag_last.valid && (tag_last.id == MAX_ID_W'(i));
        end
        for (int unsigned i = 0; i <= AES_LATENCY; i++) begin
            busy = busy | tag_q[i].valid;
        end
        resp_data = tag_last.valid ? core_out : '0;
    end

    assign req_ready  = gnt;
    assign core_state = core_state_q;
    assign core_key   = core_key_q;

endmodule

// File: tb/tb_aes_128_req_sched.sv
// Scoreboard bench for aes_128_req_sched with a fixed-latency aes_128 stand-in that
// knows the directed test vectors.
module tb_aes_128_req_sched;

    localparam int unsigned NUM_REQ     = 4;
    localparam int unsigned AES_LATENCY = 21;
    localparam int unsigned ID_W        = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b1;
    logic [NUM_REQ-1:0]   req_valid = '0;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*128-1:0] req_state;
    logic [NUM_REQ*128-1:0] req_key;
    logic [127:0]         core_state, core_key, core_out;
    logic [NUM_REQ-1:0]   resp_valid;
    logic [127:0]         resp_data;
    logic                 busy;

    logic [127:0] st [NUM_REQ];
    logic [127:0] ky [NUM_REQ];
    logic [127:0] core_pipe [AES_LATENCY];

    typedef struct {
        logic [3:0]   id;
        logic [127:0] data;
        int           due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_128_req_sched #(
        .NUM_REQ     (NUM_REQ),
        .AES_LATENCY (AES_LATENCY),
        .ID_W        (ID_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_state  (req_state),
        .req_key    (req_key),
        .core_state (core_state),
        .core_key   (core_key),
        .core_out   (core_out),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always_comb begin
        req_state = '0;
        req_key   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_state[128*i +: 128] = st[i];
            req_key[128*i +: 128]   = ky[i];
        end
    end

    // Known-answer table; any other operand pair yields a distinct scramble so
    // misrouted operands still show up as wrong data.
    function automatic logic [127:0] aes_ref(input logic [127:0] s, input logic [127:0] k);
        case ({s, k})
            {128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c}:
                return 128'h3925841d02dc09fbdc118597196a0b32;
            {128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f}:
                return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
            {128'h0, 128'h0}: return 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
            {128'h0, 128'h1}: return 128'h0545aad56da2a97c3663d1432a3d1c84;
            {128'h1, 128'h0}: return 128'h58e2fccefa7e3061367f1d57a4e7455a;
            default: return s ^ {k[63:0], k[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
        endcase
    endfunction

    always @(posedge clk) begin
        core_pipe[0] <= aes_ref(core_state, core_key);
        for (int i = 1; i < AES_LATENCY; i++) core_pipe[i] <= core_pipe[i-1];
    end
    assign core_out = core_pipe[AES_LATENCY-1];

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < 4; i++) if (oh[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // One cycle: present requests, check the grant, queue the expected response.
    task automatic step(input logic [3:0] vld, input logic [3:0] exp_gnt, input bit push,
                        output logic [3:0] got);
        int i;
        req_valid = vld;
        #1;
        got = req_ready;
        chk("req_ready", req_ready, exp_gnt);
        if (push && exp_gnt != 4'b0000) begin
            i = oh2idx(exp_gnt);
            sb.push_back('{exp_gnt, aes_ref(st[i], ky[i]), cyc + 1 + AES_LATENCY});
        end
        @(posedge clk); #2;
    endtask

    task automatic drain();
        int n = 0;
        req_valid = '0;
        while (sb.size() != 0 && n < 3 * AES_LATENCY) begin
            @(posedge clk); #2;
            n++;
        end
        chk("drain_empty", 128'(sb.size()), 128'd0);
        @(posedge clk); #2;
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (resp_valid !== 4'b0000) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: got resp_valid=%b required none (cycle %0d)",
                             resp_valid, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("resp_id", resp_valid, e.id);
                    chk("resp_data", resp_data, e.data);
                    chk("resp_cycle", 128'(cyc), 128'(e.due));
                    chk("resp_busy", busy, 1'b1);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish required finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] g;
        int cnt [4];
        for (int i = 0; i < NUM_REQ; i++) begin st[i] = '0; ky[i] = '0; end
        repeat (2) @(posedge clk);
        #2;
        // Reset state; no grant while rst_n is low.
        step(4'b1111, 4'b0000, 1'b0, g);
        rst_n = 1'b1;
        req_valid = '0;
        chk("rst_core_state", core_state, '0);
        chk("rst_core_key", core_key, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_resp_valid", resp_valid, 4'b0000);

        // Single request from requester 0.
        st[0] = 128'h3243f6a8885a308d313198a2e0370734;
        ky[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        step(4'b0001, 4'b0001, 1'b1, g);
        chk("busy_inflight", busy, 1'b1);
        chk("core_state_issue", core_state, st[0]);
        drain();

        // Back-to-back, requesters 1 and 2.
        st[1] = 128'h00112233445566778899aabbccddeeff;
        ky[1] = 128'h000102030405060708090a0b0c0d0e0f;
        st[2] = '0;
        ky[2] = '0;
        step(4'b0110, 4'b0010, 1'b1, g);
        step(4'b0100, 4'b0100, 1'b1, g);
        drain();

        // Requester 3 alone on consecutive cycles.
        st[3] = 128'h0; ky[3] = 128'h1;
        step(4'b1000, 4'b1000, 1'b1, g);
        st[3] = 128'h1; ky[3] = 128'h0;
        step(4'b1000, 4'b1000, 1'b1, g);
        drain();

        // Fairness: all valid for 40 cycles, pointer starts at 0.
        for (int i = 0; i < 4; i++) begin
            st[i] = 128'h1000 + 128'(i);
            ky[i] = {4{32'hdeadbeef}} ^ 128'(i * 7);
            cnt[i] = 0;
        end
        for (int k = 0; k < 40; k++) begin
            step(4'b1111, 4'b0001 << (k % 4), 1'b1, g);
            for (int i = 0; i < 4; i++) if (g[i]) cnt[i]++;
        end
        for (int i = 0; i < 4; i++) chk("fair_count", 128'(cnt[i]), 128'd10);
        drain();

        // en=0 while a block is in flight; grants resume from the held pointer.
        step(4'b0011, 4'b0001, 1'b1, g);
        en = 1'b0;
        repeat (25) step(4'b1111, 4'b0000, 1'b0, g);
        chk("en0_drained", 128'(sb.size()), 128'd0);
        en = 1'b1;
        step(4'b1111, 4'b0010, 1'b1, g);
        step(4'b0101, 4'b0100, 1'b1, g);
        drain();

        // Reset mid-flight: three accepted blocks must never respond.
        step(4'b0111, 4'b0001, 1'b0, g);
        step(4'b0111, 4'b0010, 1'b0, g);
        step(4'b0111, 4'b0100, 1'b0, g);
        step(4'b0000, 4'b0000, 1'b0, g);
        step(4'b0000, 4'b0000, 1'b0, g);
        rst_n = 1'b0;
        step(4'b1111, 4'b0000, 1'b0, g);
        rst_n = 1'b1;
        for (int k = 0; k < 2 * int'(AES_LATENCY); k++) begin
            if (k % 7 == 0) begin
                chk("rst_mid_busy", busy, 1'b0);
                chk("rst_mid_resp", resp_valid, 4'b0000);
            end
            step(4'b0000, 4'b0000, 1'b0, g);
        end
        st[0] = 128'h3243f6a8885a308d313198a2e0370734;
        ky[0] = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        step(4'b0001, 4'b0001, 1'b1, g);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
